// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the fetch stage and its neighbours.
package pipeline_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC     = 32'd4;
  localparam logic [XLEN-1:0] NOP        = 32'h0000_0000;
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding imem handshake
// and holds one returned instruction for the IF/ID register.
module if_fetch_unit
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INST = NOP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_IF,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] inst_IF,
  output logic [XLEN-1:0] pc_IF,
  output logic [XLEN-1:0] pc4_IF,
  output logic            if_valid
);

  fetch_state_e    state_r, state_s;
  logic [XLEN-1:0] pc_reg_r, pc_reg_s;
  logic [XLEN-1:0] pc_pend_r, pc_pend_s;
  logic            buf_open_s;
  logic            fill_s;
  logic            drop_buf_s;

  // Next-state, PC update and request generation
  always_comb begin
    state_s    = state_r;
    pc_reg_s   = pc_reg_r;
    pc_pend_s  = pc_pend_r;
    fill_s     = 1'b0;
    imem_req   = 1'b0;
    imem_addr  = pc_reg_r;
    buf_open_s = !if_valid || !stall_IF;
    drop_buf_s = redirect_valid || (if_valid && !stall_IF);

    if (redirect_valid) begin
      // In-flight responses must be swallowed before fetching the new path
      pc_reg_s = redirect_pc & ALIGN_MASK;
      case (state_r)
        WAIT:    state_s = imem_rvalid ? FETCH : DROP;
        DROP:    state_s = imem_rvalid ? FETCH : DROP;
        default: state_s = FETCH;
      endcase
    end else begin
      case (state_r)
        FETCH: begin
          imem_req = !rst && buf_open_s;
          if (imem_req && imem_ready) begin
            pc_pend_s = pc_reg_r;
            pc_reg_s  = pc_reg_r + PC_INC;
            state_s   = WAIT;
          end else begin
            state_s = FETCH;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            fill_s  = 1'b1;
            state_s = FETCH;
          end else begin
            state_s = WAIT;
          end
        end
        DROP: begin
          if (imem_rvalid) begin
            state_s = FETCH;
          end else begin
            state_s = DROP;
          end
        end
        default: state_s = FETCH;
      endcase
    end
  end

  // FSM state and PC registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= FETCH;
      pc_reg_r  <= RESET_PC;
      pc_pend_r <= 32'h0000_0000;
    end else begin
      state_r   <= state_s;
      pc_reg_r  <= pc_reg_s;
      pc_pend_r <= pc_pend_s;
    end
  end

  // One-entry instruction buffer, which also directly drives the IF outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid <= 1'b0;
      inst_IF  <= NOP_INST;
      pc_IF    <= 32'h0000_0000;
      pc4_IF   <= 32'h0000_0000;
    end else if (fill_s) begin
      if_valid <= 1'b1;
      inst_IF  <= imem_rdata;
      pc_IF    <= pc_pend_r;
      pc4_IF   <= pc_pend_r + PC_INC;
    end else if (drop_buf_s) begin
      if_valid <= 1'b0;
      inst_IF  <= NOP_INST;
      pc_IF    <= 32'h0000_0000;
      pc4_IF   <= 32'h0000_0000;
    end else begin
      if_valid <= if_valid;
      inst_IF  <= inst_IF;
      pc_IF    <= pc_IF;
      pc4_IF   <= pc4_IF;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus randomized traffic against an
// in-order instruction-stream model with a single-outstanding memory responder.
module tb_if_fetch_unit;

  localparam logic [31:0] MAGIC = 32'hA5A5_0000;
  localparam logic [31:0] ALIGN = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst, stall_IF, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ready, imem_rvalid, if_valid;
  logic [31:0] imem_addr, imem_rdata, inst_IF, pc_IF, pc4_IF;

  logic        w_rst, w_req, w_ready, w_rvalid, w_valid;
  logic [31:0] w_addr, w_rdata, w_inst, w_pc, w_pc4;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .stall_IF(stall_IF), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_IF(inst_IF), .pc_IF(pc_IF), .pc4_IF(pc4_IF), .if_valid(if_valid)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(w_rst), .stall_IF(1'b0), .redirect_valid(1'b0),
    .redirect_pc(32'h0000_0000), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(w_ready), .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .inst_IF(w_inst), .pc_IF(w_pc), .pc4_IF(w_pc4), .if_valid(w_valid)
  );

  int checks = 0;
  int errors = 0;

  // memory responder state
  bit          pend = 1'b0;
  int          lat = 0;
  logic [31:0] pend_addr = 32'h0;
  int          lat_mode = 0;
  int          ready_pct = 100;
  bit          w_pend = 1'b0;
  logic [31:0] w_pend_addr = 32'h0;

  // reference model state
  logic [31:0] exp_pc = 32'h0, exp_fetch = 32'h0;
  bit          acc_last = 1'b0;
  logic [31:0] acc_addr_last = 32'h0;
  logic [31:0] acc_q[$];
  logic [31:0] w_acc_q[$];
  logic [31:0] w_pc_q[$];
  logic [31:0] w_pc4_q[$];
  bit          hold_prev = 1'b0;
  logic [31:0] hold_inst = 32'h0, hold_pc = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check, advance memory after posedge.
  task automatic cyc(input bit st, input bit rd, input logic [31:0] rpc);
    logic [31:0] p4;
    bit          w_acc;
    stall_IF       = st;
    redirect_valid = rd;
    redirect_pc    = rpc;
    imem_rvalid    = pend && (lat == 0);
    imem_rdata     = imem_rvalid ? (pend_addr ^ MAGIC) : 32'hDEAD_BEEF;
    imem_ready     = !pend && ($urandom_range(99) < ready_pct);
    w_rvalid       = w_pend;
    w_rdata        = w_pend_addr ^ MAGIC;
    w_ready        = 1'b1;
    #1;
    w_acc = !w_rst && w_req && w_ready;
    if (w_acc) w_acc_q.push_back(w_addr);
    if (!w_rst && w_valid) begin
      w_pc_q.push_back(w_pc);
      w_pc4_q.push_back(w_pc4);
    end
    if (rst) begin
      chk("rst_req", imem_req, 1'b0);
      chk("rst_valid", if_valid, 1'b0);
      chk("rst_inst", inst_IF, 32'h0);
      chk("rst_pc", pc_IF, 32'h0);
      chk("rst_pc4", pc4_IF, 32'h0);
      exp_pc    = 32'h0;
      exp_fetch = 32'h0;
      hold_prev = 1'b0;
      acc_last  = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", if_valid, 1'b1);
        chk("hold_pc", pc_IF, hold_pc);
        chk("hold_inst", inst_IF, hold_inst);
      end
      if (if_valid && st && !rd) chk("stall_req", imem_req, 1'b0);
      if (rd) chk("redir_req", imem_req, 1'b0);
      if (if_valid) begin
        if (!st) begin
          p4 = exp_pc + 32'd4;
          chk("cons_pc", pc_IF, exp_pc);
          chk("cons_inst", inst_IF, exp_pc ^ MAGIC);
          chk("cons_pc4", pc4_IF, p4);
          exp_pc = p4;
        end
      end else begin
        chk("idle_inst", inst_IF, 32'h0);
        chk("idle_pc", pc_IF, 32'h0);
        chk("idle_pc4", pc4_IF, 32'h0);
      end
      acc_last = imem_req && imem_ready;
      if (acc_last) begin
        chk("fetch_addr", imem_addr, exp_fetch);
        acc_addr_last = imem_addr;
        acc_q.push_back(imem_addr);
        exp_fetch = exp_fetch + 32'd4;
      end
      if (rd) begin
        exp_pc    = rpc & ALIGN;
        exp_fetch = rpc & ALIGN;
      end
      hold_prev = if_valid && st && !rd;
      hold_inst = inst_IF;
      hold_pc   = pc_IF;
    end
    @(posedge clk);
    if (imem_rvalid) pend = 1'b0;
    else if (pend) lat--;
    if (acc_last) begin
      pend      = 1'b1;
      pend_addr = acc_addr_last;
      lat       = (lat_mode < 0) ? int'($urandom_range(3)) : lat_mode;
    end
    w_pend      = w_acc;
    w_pend_addr = w_addr;
    @(negedge clk);
  endtask

  task automatic wait_accept(input string tag);
    int n = 0;
    do begin
      cyc(1'b0, 1'b0, 32'h0);
      n++;
    end while (!acc_last && n < 20);
    chk(tag, acc_last, 1'b1);
  endtask

  initial begin
    logic [31:0] rpc;
    rst = 1'b1; w_rst = 1'b1;
    stall_IF = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    w_ready = 1'b0; w_rvalid = 1'b0; w_rdata = 32'h0;
    @(negedge clk);
    repeat (2) cyc(1'b0, 1'b0, 32'h0);

    // wrap-around reset PC on the second instance
    w_rst = 1'b0;
    repeat (7) cyc(1'b0, 1'b0, 32'h0);
    chk("w_fetch_count", 32'(w_acc_q.size() >= 3), 32'd1);
    if (w_acc_q.size() >= 3) begin
      chk("w_addr0", w_acc_q[0], 32'hFFFF_FFF8);
      chk("w_addr1", w_acc_q[1], 32'hFFFF_FFFC);
      chk("w_addr2", w_acc_q[2], 32'h0000_0000);
    end
    chk("w_valid_count", 32'(w_pc_q.size() >= 2), 32'd1);
    if (w_pc_q.size() >= 2) begin
      chk("w_pc0", w_pc_q[0], 32'hFFFF_FFF8);
      chk("w_pc4_0", w_pc4_q[0], 32'hFFFF_FFFC);
      chk("w_pc1", w_pc_q[1], 32'hFFFF_FFFC);
      chk("w_pc4_1", w_pc4_q[1], 32'h0000_0000);
    end
    w_rst = 1'b1;

    // zero-wait streaming from reset
    rst = 1'b0;
    acc_q.delete();
    repeat (2) cyc(1'b0, 1'b0, 32'h0);
    chk("s_valid0", if_valid, 1'b1);
    chk("s_pc0", pc_IF, 32'h0);
    chk("s_inst0", inst_IF, MAGIC);
    chk("s_pc4_0", pc4_IF, 32'h4);
    cyc(1'b0, 1'b0, 32'h0);
    chk("s_gap", if_valid, 1'b0);
    cyc(1'b0, 1'b0, 32'h0);
    chk("s_pc1", pc_IF, 32'h4);
    repeat (2) cyc(1'b0, 1'b0, 32'h0);
    chk("s_acc_count", acc_q.size(), 32'd3);
    if (acc_q.size() >= 3) begin
      chk("s_addr0", acc_q[0], 32'h0);
      chk("s_addr1", acc_q[1], 32'h4);
      chk("s_addr2", acc_q[2], 32'h8);
    end

    // stall three cycles holding pc 8
    repeat (3) begin
      cyc(1'b1, 1'b0, 32'h0);
      chk("st_pc", pc_IF, 32'h8);
    end
    cyc(1'b0, 1'b0, 32'h0);
    chk("st_next_acc", acc_last, 1'b1);
    chk("st_next_addr", acc_addr_last, 32'hC);

    // redirect while waiting; response arrives two cycles later
    lat_mode = 2;
    wait_accept("rw_accept");
    cyc(1'b0, 1'b1, 32'h0000_0103);
    repeat (2) begin
      cyc(1'b0, 1'b0, 32'h0);
      chk("rw_no_valid", if_valid, 1'b0);
    end
    cyc(1'b0, 1'b0, 32'h0);
    chk("rw_acc", acc_last, 1'b1);
    chk("rw_addr", acc_addr_last, 32'h0000_0100);

    // redirect in the same cycle as rvalid
    lat_mode = 0;
    wait_accept("rr_accept");
    cyc(1'b0, 1'b1, 32'h0000_0200);
    chk("rr_no_valid", if_valid, 1'b0);
    cyc(1'b0, 1'b0, 32'h0);
    chk("rr_acc", acc_last, 1'b1);
    chk("rr_addr", acc_addr_last, 32'h0000_0200);

    // reset during WAIT with a stale response after release
    lat_mode = 3;
    wait_accept("rs_accept");
    rst = 1'b1;
    lat_mode = 0;
    cyc(1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    repeat (3) begin
      cyc(1'b0, 1'b0, 32'h0);
      chk("rs_no_valid", if_valid, 1'b0);
    end
    cyc(1'b0, 1'b0, 32'h0);
    chk("rs_acc", acc_last, 1'b1);
    chk("rs_addr", acc_addr_last, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    chk("rs_valid", if_valid, 1'b1);
    chk("rs_pc", pc_IF, 32'h0);
    chk("rs_inst", inst_IF, MAGIC);

    // randomized traffic
    lat_mode  = -1;
    ready_pct = 70;
    for (int i = 0; i < 3000; i++) begin
      rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      cyc(($urandom_range(3) == 0), ($urandom_range(15) == 0), rpc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
